// File: rtl/w0rm_core_pkg.sv
// Shared helpers for the w0rm core register file slice.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
// Contents: MAX_READ_PORTS, clog2_min1() address-width helper,
//           slice_lsb() operand/address packing helper.
package w0rm_core_pkg;

  // Largest legal NUM_READ_PORTS for the register file.
  localparam int MAX_READ_PORTS = 4;

  // ceil(log2(value)), never less than 1 so a single-entry file still has an address bit.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    for (int w = 1; w < 31; w++) begin
      if ((1 << w) < value) width = w + 1;
    end
    return width;
  endfunction

  // LSB of lane 'port' in a flat bus of 'width'-bit lanes (lane 0 in the low bits).
  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/w0rm_core_scoreboard.sv
// Pending-destination scoreboard with per-port RAW and WAW hazard lookup.
// Latency: hazard is combinational from the pending vector; set/clear take effect at the next edge.
// Backpressure: none itself; the hazard output is what stalls decode.
// Ports:
//   clk, reset_n, flush            - clock, sync active-low reset, pipeline flush (clears all pending)
//   set_en / set_addr              - mark a destination in flight (accepted instruction)
//   clear_en / clear_addr          - writeback retires a destination
//   src_addr / src_en / src_bypass - packed source addresses, use mask, per-port forwarding mask
//   dest_addr / dest_en            - destination of the presented instruction (WAW check)
//   hazard                         - presented instruction must not issue
module w0rm_core_scoreboard
  import w0rm_core_pkg::*;
#(
  parameter int NUM_REGISTERS  = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 flush,
  input  logic                                 set_en,
  input  logic [ADDR_WIDTH-1:0]                set_addr,
  input  logic                                 clear_en,
  input  logic [ADDR_WIDTH-1:0]                clear_addr,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] src_addr,
  input  logic [NUM_READ_PORTS-1:0]            src_en,
  input  logic [NUM_READ_PORTS-1:0]            src_bypass,
  input  logic [ADDR_WIDTH-1:0]                dest_addr,
  input  logic                                 dest_en,
  output logic                                 hazard
);

  logic [NUM_REGISTERS-1:0] pending;
  logic [NUM_REGISTERS-1:0] pending_nxt;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    return int'(addr) < NUM_REGISTERS;
  endfunction

  // Clear first, then set: an accept that targets the register being written back stays pending.
  always_comb begin
    pending_nxt = pending;
    if (clear_en && addr_ok(clear_addr)) pending_nxt[clear_addr] = 1'b0;
    if (set_en && addr_ok(set_addr))     pending_nxt[set_addr]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  logic [ADDR_WIDTH-1:0] port_addr [NUM_READ_PORTS];

  for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_port_addr
    assign port_addr[g] = src_addr[slice_lsb(g, ADDR_WIDTH) +: ADDR_WIDTH];
  end

  // A forwarded source sees its register as already retired; the destination check never does.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      if (src_en[i] && !src_bypass[i] && addr_ok(port_addr[i]) && pending[port_addr[i]]) begin
        hazard = 1'b1;
      end
    end
    if (dest_en && addr_ok(dest_addr) && pending[dest_addr]) hazard = 1'b1;
  end

endmodule

// File: rtl/w0rm_core_register_file_mp.sv
// N-read-port register file with scoreboard and a registered operand-fetch stage (decode -> ALU).
// Latency: accept to rfetch_valid is 1 cycle; 1 instruction/cycle when hazard-free and alu_ready high.
// Backpressure: reg_file_ready drops on hazard, flush, reset or a full operand stage; rfetch_* hold while !alu_ready.
// Ports:
//   clk, reset_n, flush                         - clock, sync active-low reset, pipeline flush
//   decode_valid / reg_file_ready / hazard_stall - decode handshake and stall indication
//   decode_read_addr / decode_read_en           - packed source addresses (port i at i*ADDR_WIDTH), use mask
//   decode_dest_addr / decode_dest_en           - destination of the presented instruction
//   rfetch_valid / alu_ready                    - operand stage handshake
//   rfetch_data / rfetch_dest_addr / rfetch_dest_en - registered operands (port i at i*DATA_WIDTH) and dest
//   port_write_addr / _enable / _data           - writeback port
// Option: define W0RM_REGFILE_BYPASS_EN to forward writeback data to sources in the same cycle.
module w0rm_core_register_file_mp
  import w0rm_core_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int NUM_REGISTERS  = 16,
  parameter  int NUM_READ_PORTS = 2,
  localparam int ADDR_WIDTH     = clog2_min1(NUM_REGISTERS)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 flush,
  input  logic                                 decode_valid,
  output logic                                 reg_file_ready,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] decode_read_addr,
  input  logic [NUM_READ_PORTS-1:0]            decode_read_en,
  input  logic [ADDR_WIDTH-1:0]                decode_dest_addr,
  input  logic                                 decode_dest_en,
  output logic                                 rfetch_valid,
  input  logic                                 alu_ready,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rfetch_data,
  output logic [ADDR_WIDTH-1:0]                rfetch_dest_addr,
  output logic                                 rfetch_dest_en,
  input  logic [ADDR_WIDTH-1:0]                port_write_addr,
  input  logic                                 port_write_enable,
  input  logic [DATA_WIDTH-1:0]                port_write_data,
  output logic                                 hazard_stall
);

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    return int'(addr) < NUM_REGISTERS;
  endfunction

  logic [DATA_WIDTH-1:0]                regs [NUM_REGISTERS];
  logic [ADDR_WIDTH-1:0]                src_addr [NUM_READ_PORTS];
  logic [NUM_READ_PORTS-1:0]            src_bypass;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] operand;
  logic                                 write_ok;
  logic                                 hazard;
  logic                                 accept;

  assign write_ok = port_write_enable && addr_ok(port_write_addr);

  for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_src_addr
    assign src_addr[g] = decode_read_addr[slice_lsb(g, ADDR_WIDTH) +: ADDR_WIDTH];
  end

  // Operand select per port: array value (0 for out-of-range addresses), optionally overridden
  // by same-cycle writeback data. Forwarding applies whether or not the port's read_en is set.
  always_comb begin
    src_bypass = '0;
    operand    = '0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      if (addr_ok(src_addr[i])) begin
        operand[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = regs[src_addr[i]];
      end
`ifdef W0RM_REGFILE_BYPASS_EN
      if (write_ok && (src_addr[i] == port_write_addr)) begin
        src_bypass[i] = 1'b1;
        operand[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = port_write_data;
      end
`endif
    end
  end

  w0rm_core_scoreboard #(
    .NUM_REGISTERS  (NUM_REGISTERS),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .NUM_READ_PORTS (NUM_READ_PORTS)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .set_en     (accept && decode_dest_en),
    .set_addr   (decode_dest_addr),
    .clear_en   (port_write_enable),
    .clear_addr (port_write_addr),
    .src_addr   (decode_read_addr),
    .src_en     (decode_read_en),
    .src_bypass (src_bypass),
    .dest_addr  (decode_dest_addr),
    .dest_en    (decode_dest_en),
    .hazard     (hazard)
  );

  assign reg_file_ready = reset_n && !flush && (!rfetch_valid || alu_ready) && !hazard;
  assign hazard_stall   = reset_n && decode_valid && hazard;
  assign accept         = decode_valid && reg_file_ready;

  // Register array; a writeback during flush still lands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGISTERS; r++) regs[r] <= '0;
    end else if (write_ok) begin
      regs[port_write_addr] <= port_write_data;
    end
  end

  // Operand stage. Data and dest only move on accept, so they are stable under backpressure
  // and keep their last value after the ALU drains the stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rfetch_valid     <= 1'b0;
      rfetch_data      <= '0;
      rfetch_dest_addr <= '0;
      rfetch_dest_en   <= 1'b0;
    end else if (flush) begin
      rfetch_valid <= 1'b0;
    end else if (accept) begin
      rfetch_valid     <= 1'b1;
      rfetch_data      <= operand;
      rfetch_dest_addr <= decode_dest_addr;
      rfetch_dest_en   <= decode_dest_en;
    end else if (alu_ready) begin
      rfetch_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_w0rm_core_register_file_mp.sv
// Self-checking bench for w0rm_core_register_file_mp (DATA_WIDTH=8, NUM_REGISTERS=4, NUM_READ_PORTS=3).
// Inputs change 1 time unit after the rising edge, combinational outputs are checked 1 unit later,
// and the operand stage is checked against a queue of expected operands at the falling edge.
module tb_w0rm_core_register_file_mp;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        decode_valid;
  logic        reg_file_ready;
  logic [5:0]  decode_read_addr;
  logic [2:0]  decode_read_en;
  logic [1:0]  decode_dest_addr;
  logic        decode_dest_en;
  logic        rfetch_valid;
  logic        alu_ready;
  logic [23:0] rfetch_data;
  logic [1:0]  rfetch_dest_addr;
  logic        rfetch_dest_en;
  logic [1:0]  port_write_addr;
  logic        port_write_enable;
  logic [7:0]  port_write_data;
  logic        hazard_stall;

  w0rm_core_register_file_mp #(
    .DATA_WIDTH     (8),
    .NUM_REGISTERS  (4),
    .NUM_READ_PORTS (3)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .flush             (flush),
    .decode_valid      (decode_valid),
    .reg_file_ready    (reg_file_ready),
    .decode_read_addr  (decode_read_addr),
    .decode_read_en    (decode_read_en),
    .decode_dest_addr  (decode_dest_addr),
    .decode_dest_en    (decode_dest_en),
    .rfetch_valid      (rfetch_valid),
    .alu_ready         (alu_ready),
    .rfetch_data       (rfetch_data),
    .rfetch_dest_addr  (rfetch_dest_addr),
    .rfetch_dest_en    (rfetch_dest_en),
    .port_write_addr   (port_write_addr),
    .port_write_enable (port_write_enable),
    .port_write_data   (port_write_data),
    .hazard_stall      (hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  waddr;
    logic [7:0]  wdata;
    logic        dv;
    logic [5:0]  raddr;
    logic [2:0]  ren;
    logic [1:0]  dest;
    logic        den;
    logic        exp_ready;
    logic        exp_stall;
    logic [23:0] exp_data;
  } vec_t;

  typedef struct {
    logic [23:0] data;
    logic [1:0]  dest;
    logic        den;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[10];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                              input logic dv, input logic [5:0] ra, input logic [2:0] ren,
                              input logic [1:0] d, input logic den,
                              input logic er, input logic es, input logic [23:0] ed);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd;
    v.dv = dv; v.raddr = ra; v.ren = ren; v.dest = d; v.den = den;
    v.exp_ready = er; v.exp_stall = es; v.exp_data = ed;
    return v;
  endfunction

  task automatic set_in(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                        input logic dv, input logic [5:0] ra, input logic [2:0] ren,
                        input logic [1:0] d, input logic den);
    port_write_enable = we;
    port_write_addr   = wa;
    port_write_data   = wd;
    decode_valid      = dv;
    decode_read_addr  = ra;
    decode_read_en    = ren;
    decode_dest_addr  = d;
    decode_dest_en    = den;
  endtask

  task automatic push(input logic [23:0] data, input logic [1:0] d, input logic den);
    exp_t e;
    e.data = data; e.dest = d; e.den = den;
    exp_q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Operand-stage scoreboard: a transfer happens on each edge where valid and alu_ready are high.
  always @(negedge clk) begin
    if (mon_en && reset_n === 1'b1 && rfetch_valid === 1'b1 && alu_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rfetch", {31'd0, rfetch_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rfetch_data", {8'd0, rfetch_data}, {8'd0, e.data});
        chk("rfetch_dest_addr", {30'd0, rfetch_dest_addr}, {30'd0, e.dest});
        chk("rfetch_dest_en", {31'd0, rfetch_dest_en}, {31'd0, e.den});
      end
    end
  end

  initial begin
    // Read-address packing is {port2, port1, port0}; expected data likewise.
    tbl[0] = mk(1, 2'd1, 8'h11, 0, 6'd0, 3'b000, 2'd0, 0, 1, 0, 24'h0);
    tbl[1] = mk(1, 2'd2, 8'h22, 0, 6'd0, 3'b000, 2'd0, 0, 1, 0, 24'h0);
    tbl[2] = mk(1, 2'd3, 8'h33, 0, 6'd0, 3'b000, 2'd0, 0, 1, 0, 24'h0);
    tbl[3] = mk(0, 2'd0, 8'h00, 1, {2'd3, 2'd2, 2'd1}, 3'b111, 2'd0, 0, 1, 0, 24'h332211);
    tbl[4] = mk(0, 2'd0, 8'h00, 1, {2'd3, 2'd0, 2'd1}, 3'b101, 2'd3, 1, 1, 0, 24'h330011);
    tbl[5] = mk(0, 2'd0, 8'h00, 1, {2'd2, 2'd2, 2'd2}, 3'b000, 2'd0, 0, 1, 0, 24'h222222);
    tbl[6] = mk(0, 2'd0, 8'h00, 1, {2'd0, 2'd0, 2'd3}, 3'b001, 2'd0, 0, 0, 1, 24'h0);
    tbl[7] = mk(0, 2'd0, 8'h00, 1, 6'd0, 3'b000, 2'd3, 1, 0, 1, 24'h0);
    tbl[8] = mk(1, 2'd3, 8'h77, 0, 6'd0, 3'b000, 2'd0, 0, 1, 0, 24'h0);
    tbl[9] = mk(0, 2'd0, 8'h00, 1, {2'd2, 2'd1, 2'd3}, 3'b111, 2'd0, 0, 1, 0, 24'h221177);

    // Reset: ready/stall forced low even with decode_valid high.
    reset_n = 1'b0; flush = 1'b0; alu_ready = 1'b1;
    set_in(0, 2'd0, 8'h00, 1, 6'd0, 3'b000, 2'd0, 0);
    #2;
    chk("reset_ready", {31'd0, reg_file_ready}, 32'd0);
    chk("reset_stall", {31'd0, hazard_stall}, 32'd0);
    nxt(); nxt();
    chk("reset_rfetch_valid", {31'd0, rfetch_valid}, 32'd0);
    chk("reset_rfetch_data", {8'd0, rfetch_data}, 32'd0);
    chk("reset_rfetch_dest_addr", {30'd0, rfetch_dest_addr}, 32'd0);
    chk("reset_rfetch_dest_en", {31'd0, rfetch_dest_en}, 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Table: writes, back-to-back accepts, RAW and WAW stalls, retire.
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].dv, tbl[i].raddr, tbl[i].ren,
             tbl[i].dest, tbl[i].den);
      #1;
      chk($sformatf("tbl%0d_ready", i), {31'd0, reg_file_ready}, {31'd0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_stall", i), {31'd0, hazard_stall}, {31'd0, tbl[i].exp_stall});
      if (tbl[i].dv && tbl[i].exp_ready) push(tbl[i].exp_data, tbl[i].dest, tbl[i].den);
      nxt();
    end

    // RAW on R2 until writeback of 0x5A.
    set_in(0, 2'd0, 8'h00, 1, {2'd1, 2'd1, 2'd1}, 3'b000, 2'd2, 1);
    #1; chk("raw_issue_ready", {31'd0, reg_file_ready}, 32'd1);
    push(24'h111111, 2'd2, 1'b1);
    nxt();
    set_in(0, 2'd0, 8'h00, 1, {2'd0, 2'd2, 2'd0}, 3'b010, 2'd0, 0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("raw_wait_stall", {31'd0, hazard_stall}, 32'd1);
      chk("raw_wait_ready", {31'd0, reg_file_ready}, 32'd0);
      nxt();
    end
    set_in(1, 2'd2, 8'h5A, 1, {2'd0, 2'd2, 2'd0}, 3'b010, 2'd0, 0);
    #1;
`ifdef W0RM_REGFILE_BYPASS_EN
    chk("raw_wb_ready", {31'd0, reg_file_ready}, 32'd1);
    chk("raw_wb_stall", {31'd0, hazard_stall}, 32'd0);
    push(24'h005A00, 2'd0, 1'b0);
    nxt();
`else
    chk("raw_wb_ready", {31'd0, reg_file_ready}, 32'd0);
    chk("raw_wb_stall", {31'd0, hazard_stall}, 32'd1);
    nxt();
    set_in(0, 2'd0, 8'h00, 1, {2'd0, 2'd2, 2'd0}, 3'b010, 2'd0, 0);
    #1;
    chk("raw_after_ready", {31'd0, reg_file_ready}, 32'd1);
    chk("raw_after_stall", {31'd0, hazard_stall}, 32'd0);
    push(24'h005A00, 2'd0, 1'b0);
    nxt();
`endif

    // Backpressure: alu_ready low for 3 cycles holds the operand stage.
    set_in(0, 2'd0, 8'h00, 1, {2'd1, 2'd2, 2'd3}, 3'b111, 2'd2, 0);
    #1; chk("bp_issue_ready", {31'd0, reg_file_ready}, 32'd1);
    push(24'h115A77, 2'd2, 1'b0);
    nxt();
    alu_ready = 1'b0;
    set_in(0, 2'd0, 8'h00, 1, 6'd0, 3'b000, 2'd0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", {31'd0, reg_file_ready}, 32'd0);
      chk("bp_valid", {31'd0, rfetch_valid}, 32'd1);
      chk("bp_data", {8'd0, rfetch_data}, 32'h00115A77);
      chk("bp_dest_addr", {30'd0, rfetch_dest_addr}, 32'd2);
      chk("bp_dest_en", {31'd0, rfetch_dest_en}, 32'd0);
      nxt();
    end
    alu_ready = 1'b1;
    #1; chk("bp_release_ready", {31'd0, reg_file_ready}, 32'd1);
    push(24'h000000, 2'd0, 1'b0);
    nxt();

    // Flush with R3 pending; writeback of R0 during flush still lands.
    set_in(0, 2'd0, 8'h00, 1, 6'd0, 3'b000, 2'd3, 1);
    #1; chk("fl_issue_ready", {31'd0, reg_file_ready}, 32'd1);
    push(24'h000000, 2'd3, 1'b1);
    nxt();
    flush = 1'b1; alu_ready = 1'b0;
    set_in(1, 2'd0, 8'h99, 1, {2'd0, 2'd0, 2'd3}, 3'b001, 2'd0, 0);
    #1;
    chk("fl_ready", {31'd0, reg_file_ready}, 32'd0);
    chk("fl_pending_stall", {31'd0, hazard_stall}, 32'd1);
    exp_q.delete();
    nxt();
    flush = 1'b0; alu_ready = 1'b1;
    set_in(0, 2'd0, 8'h00, 1, {2'd0, 2'd0, 2'd3}, 3'b001, 2'd0, 0);
    #1;
    chk("fl_after_valid", {31'd0, rfetch_valid}, 32'd0);
    chk("fl_after_ready", {31'd0, reg_file_ready}, 32'd1);
    chk("fl_after_stall", {31'd0, hazard_stall}, 32'd0);
    push(24'h999977, 2'd0, 1'b0);
    nxt();

    // Set wins over a same-cycle clear of the same register.
    set_in(1, 2'd1, 8'h42, 1, 6'd0, 3'b000, 2'd1, 1);
    #1; chk("sw_issue_ready", {31'd0, reg_file_ready}, 32'd1);
    push(24'h999999, 2'd1, 1'b1);
    nxt();
    set_in(0, 2'd0, 8'h00, 1, {2'd0, 2'd0, 2'd1}, 3'b001, 2'd0, 0);
    #1;
    chk("sw_pending_stall", {31'd0, hazard_stall}, 32'd1);
    chk("sw_pending_ready", {31'd0, reg_file_ready}, 32'd0);
    nxt();
    set_in(1, 2'd1, 8'h44, 0, 6'd0, 3'b000, 2'd0, 0);
    #1; chk("sw_wb_ready", {31'd0, reg_file_ready}, 32'd1);
    nxt();
    set_in(0, 2'd0, 8'h00, 1, {2'd1, 2'd0, 2'd0}, 3'b100, 2'd0, 0);
    #1; chk("sw_read_ready", {31'd0, reg_file_ready}, 32'd1);
    push(24'h449999, 2'd0, 1'b0);
    nxt();

    // Reset mid-stream with the operand stage full and R3 pending.
    set_in(0, 2'd0, 8'h00, 1, {2'd1, 2'd1, 2'd1}, 3'b111, 2'd3, 1);
    #1; chk("rs_issue_ready", {31'd0, reg_file_ready}, 32'd1);
    push(24'h444444, 2'd3, 1'b1);
    nxt();
    reset_n = 1'b0; alu_ready = 1'b0;
    set_in(0, 2'd0, 8'h00, 1, {2'd0, 2'd0, 2'd3}, 3'b001, 2'd3, 1);
    #1;
    chk("rs_valid_before", {31'd0, rfetch_valid}, 32'd1);
    chk("rs_ready", {31'd0, reg_file_ready}, 32'd0);
    chk("rs_stall", {31'd0, hazard_stall}, 32'd0);
    exp_q.delete();
    nxt();
    chk("rs_valid", {31'd0, rfetch_valid}, 32'd0);
    chk("rs_data", {8'd0, rfetch_data}, 32'd0);
    chk("rs_dest_addr", {30'd0, rfetch_dest_addr}, 32'd0);
    chk("rs_dest_en", {31'd0, rfetch_dest_en}, 32'd0);
    reset_n = 1'b1; alu_ready = 1'b1;
    set_in(0, 2'd0, 8'h00, 1, {2'd1, 2'd2, 2'd3}, 3'b111, 2'd3, 1);
    #1;
    chk("rs_after_ready", {31'd0, reg_file_ready}, 32'd1);
    chk("rs_after_stall", {31'd0, hazard_stall}, 32'd0);
    push(24'h000000, 2'd3, 1'b1);
    nxt();

    set_in(0, 2'd0, 8'h00, 0, 6'd0, 3'b000, 2'd0, 0);
    nxt(); nxt(); nxt();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
